// File: rtl/key_matrix_emulator.sv
// -----------------------------------------------------------------------------
// key_matrix_emulator
//
// Emulates one key of a 4x4 active-low keypad matrix. When a key request is
// accepted the selected contact closes for PRESS_CYCLES clocks. It is then
// held open for RELEASE_CYCLES clocks before the next request is accepted.
// While the contact is closed, the selected row follows the selected column
// with one clock of latency.
//
// Optional feature (macro KEY_EMU_BOUNCE_EN):
//   When defined, a bounce window of BOUNCE_CYCLES clocks precedes and follows
//   the press. Inside a window the contact toggles every BOUNCE_TOGGLE clocks.
//   It starts closed on the way in and open on the way out.
//   When undefined, the bounce windows do not exist and IDLE -> PRESS ->
//   RELEASE -> IDLE.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   col_data   in   [3:0] column drive from scanner, active-low, bit 3 = col 0
//   key_valid  in   key request valid (taken only while key_ready=1)
//   key_code   in   [3:2] row index, [1:0] column index
//   key_abort  in   force early release during bounce-in / press / bounce-out
//   key_ready  out  request can be accepted
//   row_data   out  [3:0] registered row sense, active-low, bit 3 = row 0
//   busy       out  high in every state except IDLE
//   done       out  one-clock pulse when a key cycle completes
// -----------------------------------------------------------------------------
module key_matrix_emulator #(
  parameter int unsigned PRESS_CYCLES   = 2_500_000,
  parameter int unsigned RELEASE_CYCLES = 2_500_000,
  parameter int unsigned BOUNCE_CYCLES  = 50_000,
  parameter int unsigned BOUNCE_TOGGLE  = 1_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_data,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       key_abort,
  output logic       key_ready,
  output logic [3:0] row_data,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    BOUNCE_IN  = 3'd1,
    PRESS      = 3'd2,
    BOUNCE_OUT = 3'd3,
    RELEASE    = 3'd4
  } state_t;

  // The counter is loaded with N-1 so that a state lasts exactly N clocks.
  // Zero is clamped to one clock.
  localparam logic [23:0] PRESS_LOAD   = (PRESS_CYCLES   > 1) ? 24'(PRESS_CYCLES - 1)   : 24'd0;
  localparam logic [23:0] RELEASE_LOAD = (RELEASE_CYCLES > 1) ? 24'(RELEASE_CYCLES - 1) : 24'd0;
`ifdef KEY_EMU_BOUNCE_EN
  localparam logic [23:0] BOUNCE_LOAD  = (BOUNCE_CYCLES  > 1) ? 24'(BOUNCE_CYCLES - 1)  : 24'd0;
  localparam logic [23:0] TOGGLE_LOAD  = (BOUNCE_TOGGLE  > 1) ? 24'(BOUNCE_TOGGLE - 1)  : 24'd0;
`endif

  state_t      state_reg, state_next;
  logic [23:0] cnt_reg, cnt_next;
  logic [3:0]  code_reg, code_next;
  logic [3:0]  row_reg, row_next;
  logic        done_reg, done_next;
  logic        contact_closed;
  logic        accept;
  logic        cnt_zero;

  assign cnt_zero  = (cnt_reg == 24'd0);
  assign key_ready = (state_reg == IDLE) && !done_reg;
  assign accept    = key_ready && key_valid;
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign row_data  = row_reg;

`ifdef KEY_EMU_BOUNCE_EN
  // Bounce contact: phase_reg is the contact level inside a bounce window.
  // toggle_reg counts clocks until the next flip.
  logic        phase_reg, phase_next;
  logic [23:0] toggle_reg, toggle_next;

  always_comb begin
    phase_next  = phase_reg;
    toggle_next = toggle_reg;
    if (state_next == BOUNCE_IN && state_reg != BOUNCE_IN) begin
      phase_next  = 1'b1;
      toggle_next = TOGGLE_LOAD;
    end else if (state_next == BOUNCE_OUT && state_reg != BOUNCE_OUT) begin
      phase_next  = 1'b0;
      toggle_next = TOGGLE_LOAD;
    end else if (state_reg == BOUNCE_IN || state_reg == BOUNCE_OUT) begin
      if (toggle_reg == 24'd0) begin
        phase_next  = ~phase_reg;
        toggle_next = TOGGLE_LOAD;
      end else begin
        toggle_next = toggle_reg - 24'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_reg  <= 1'b0;
      toggle_reg <= 24'd0;
    end else begin
      phase_reg  <= phase_next;
      toggle_reg <= toggle_next;
    end
  end

  always_comb begin
    case (state_reg)
      PRESS:      contact_closed = 1'b1;
      BOUNCE_IN,
      BOUNCE_OUT: contact_closed = phase_reg;
      default:    contact_closed = 1'b0;
    endcase
  end
`else
  assign contact_closed = (state_reg == PRESS);
`endif

  // Next-state logic and counter control.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_zero ? 24'd0 : (cnt_reg - 24'd1);
    code_next  = code_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          code_next  = key_code;
`ifdef KEY_EMU_BOUNCE_EN
          state_next = BOUNCE_IN;
          cnt_next   = BOUNCE_LOAD;
`else
          state_next = PRESS;
          cnt_next   = PRESS_LOAD;
`endif
        end
      end
`ifdef KEY_EMU_BOUNCE_EN
      BOUNCE_IN: begin
        if (key_abort) begin
          state_next = RELEASE;
          cnt_next   = RELEASE_LOAD;
        end else if (cnt_zero) begin
          state_next = PRESS;
          cnt_next   = PRESS_LOAD;
        end
      end
      BOUNCE_OUT: begin
        if (key_abort || cnt_zero) begin
          state_next = RELEASE;
          cnt_next   = RELEASE_LOAD;
        end
      end
`endif
      PRESS: begin
        if (key_abort) begin
          state_next = RELEASE;
          cnt_next   = RELEASE_LOAD;
        end else if (cnt_zero) begin
`ifdef KEY_EMU_BOUNCE_EN
          state_next = BOUNCE_OUT;
          cnt_next   = BOUNCE_LOAD;
`else
          state_next = RELEASE;
          cnt_next   = RELEASE_LOAD;
`endif
        end
      end
      RELEASE: begin
        if (cnt_zero) begin
          state_next = IDLE;
          cnt_next   = 24'd0;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 24'd0;
      end
    endcase
  end

  // Row sense: only the latched row follows the latched column, and only
  // while the contact is closed. ~index maps index r to bit 3-r.
  logic [1:0] row_sel;
  logic       col_bit;
  assign row_sel = ~code_reg[3:2];
  assign col_bit = col_data[~code_reg[1:0]];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
      assign row_next[gi] = (contact_closed && (row_sel == 2'(gi))) ? col_bit : 1'b1;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 24'd0;
      code_reg  <= 4'd0;
      row_reg   <= 4'b1111;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      code_reg  <= code_next;
      row_reg   <= row_next;
      done_reg  <= done_next;
    end
  end

endmodule

// File: tb/tb_key_matrix_emulator.sv
// -----------------------------------------------------------------------------
// tb_key_matrix_emulator
//
// Directed self-checking bench for key_matrix_emulator with PRESS=20,
// RELEASE=10, BOUNCE=8, TOGGLE=2. Builds with or without KEY_EMU_BOUNCE_EN;
// the bounce window lengths below follow the macro.
// -----------------------------------------------------------------------------
module tb_key_matrix_emulator;

`ifdef KEY_EMU_BOUNCE_EN
  localparam int BIN  = 8;
  localparam int BOUT = 8;
`else
  localparam int BIN  = 0;
  localparam int BOUT = 0;
`endif
  localparam int NPRESS = 20;
  localparam int NREL   = 10;
  localparam int TOTAL  = BIN + NPRESS + BOUT + NREL;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] col_data = 4'b1111;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'b0000;
  logic       key_abort = 1'b0;
  logic       key_ready;
  logic [3:0] row_data;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  key_matrix_emulator #(
    .PRESS_CYCLES  (20),
    .RELEASE_CYCLES(10),
    .BOUNCE_CYCLES (8),
    .BOUNCE_TOGGLE (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .col_data (col_data),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_abort(key_abort),
    .key_ready(key_ready),
    .row_data (row_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Contact level during the idx-th cycle after the acceptance edge.
  function automatic bit exp_closed(input int idx);
    int i;
    i = idx;
    if (i < BIN) return ((i / 2) % 2) == 0;
    i -= BIN;
    if (i < NPRESS) return 1'b1;
    i -= NPRESS;
    if (i < BOUT) return ((i / 2) % 2) == 1;
    return 1'b0;
  endfunction

  task automatic accept_key(input logic [3:0] code);
    key_code  = code;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (row_data !== 4'b1111) begin n_bad++; $display("FAIL reset_row: got %b, required 1111", row_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b, required 0", done); end
    n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b, required 1", key_ready); end
    rst_n = 1'b1;
    $display("reset: row=%b busy=%b done=%b ready=%b", row_data, busy, done, key_ready);
  endtask

  task automatic test_press_held;
    logic [3:0] exp_row;
    col_data = 4'b1101;
    accept_key(4'b0110);
    key_code = 4'b1111;  // later code changes must not matter
    for (int k = 1; k <= TOTAL + 1; k++) begin
      @(posedge clk); #1;
      exp_row = exp_closed(k - 1) ? 4'b1011 : 4'b1111;
      n_cmp++; if (row_data !== exp_row) begin n_bad++; $display("FAIL held_row k=%0d: got %b, required %b", k, row_data, exp_row); end
      n_cmp++; if (done !== (k == TOTAL)) begin n_bad++; $display("FAIL held_done k=%0d: got %b, required %b", k, done, (k == TOTAL)); end
      n_cmp++; if (busy !== (k < TOTAL)) begin n_bad++; $display("FAIL held_busy k=%0d: got %b, required %b", k, busy, (k < TOTAL)); end
      n_cmp++; if (key_ready !== (k > TOTAL)) begin n_bad++; $display("FAIL held_ready k=%0d: got %b, required %b", k, key_ready, (k > TOTAL)); end
    end
    $display("press_held: code=0110 col=1101 done at clock %0d", TOTAL);
  endtask

  task automatic test_col_cycle;
    logic [3:0] pat [4];
    logic [3:0] cur, exp_row;
    int ci;
    pat[0] = 4'b0111; pat[1] = 4'b1011; pat[2] = 4'b1101; pat[3] = 4'b1110;
    ci = 0;
    col_data = pat[0];
    accept_key(4'b0110);
    cur = col_data;
    for (int k = 1; k <= TOTAL + 1; k++) begin
      @(posedge clk); #1;
      exp_row = (exp_closed(k - 1) && cur == 4'b1101) ? 4'b1011 : 4'b1111;
      n_cmp++; if (row_data !== exp_row) begin n_bad++; $display("FAIL cycle_row k=%0d: got %b, required %b", k, row_data, exp_row); end
      ci++;
      cur = pat[ci % 4];
      col_data = cur;
    end
    $display("col_cycle: code=0110 rotating columns checked over %0d clocks", TOTAL + 1);
  endtask

  task automatic test_other_key;
    col_data = 4'b0111;
    accept_key(4'b1100);
    for (int k = 1; k <= TOTAL + 1; k++) begin
      @(posedge clk); #1;
      if (k == BIN + 1) begin
        n_cmp++; if (row_data !== 4'b1110) begin n_bad++; $display("FAIL other_row: got %b, required 1110", row_data); end
      end
      if (k == TOTAL) begin
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL other_done: got %b, required 1", done); end
      end
    end
    $display("other_key: code=1100 col=0111 row=1110 expected");
  endtask

  task automatic test_abort;
    col_data = 4'b1101;
    accept_key(4'b0110);
    for (int k = 1; k <= BIN + 17; k++) begin
      @(posedge clk); #1;
      if (k == BIN + 4) begin
        key_abort = 1'b1;
        key_valid = 1'b1;
        key_code  = 4'b0000;
      end
      if (k == BIN + 5) begin
        key_abort = 1'b0;
        n_cmp++; if (row_data !== 4'b1011) begin n_bad++; $display("FAIL abort_row_edge: got %b, required 1011", row_data); end
        n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL abort_ready_busy: got %b, required 0", key_ready); end
      end
      if (k == BIN + 6) begin
        n_cmp++; if (row_data !== 4'b1111) begin n_bad++; $display("FAIL abort_row_open: got %b, required 1111", row_data); end
      end
      if (k == BIN + 14) key_valid = 1'b0;
      if (k >= BIN + 5 && k <= BIN + 15) begin
        n_cmp++; if (done !== (k == BIN + 15)) begin n_bad++; $display("FAIL abort_done k=%0d: got %b, required %b", k, done, (k == BIN + 15)); end
      end
      if (k >= BIN + 15) begin
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy k=%0d: got %b, required 0", k, busy); end
      end
      if (k == BIN + 16) begin
        n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b, required 1", key_ready); end
      end
    end
    $display("abort: abort at press clock 5, done 10 clocks later");
  endtask

  task automatic test_reset_mid;
    logic seen_done;
    col_data = 4'b1101;
    accept_key(4'b0110);
    for (int k = 1; k <= BIN + 10; k++) begin
      @(posedge clk); #1;
      if (k == BIN + 9) rst_n = 1'b0;
    end
    n_cmp++; if (row_data !== 4'b1111) begin n_bad++; $display("FAIL midrst_row: got %b, required 1111", row_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b, required 1", key_ready); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b, required 0", done); end
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < TOTAL + 5; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done = 1'b1;
    end
    n_cmp++; if (seen_done !== 1'b0) begin n_bad++; $display("FAIL midrst_no_done: got %b, required 0", seen_done); end
    $display("reset_mid: reset at press clock 10, contact released, no done");
  endtask

`ifdef KEY_EMU_BOUNCE_EN
  task automatic test_bounce;
    logic [45:0] exp_seq;
    exp_seq = {8'b00110011, 20'd0, 8'b11001100, 10'b1111111111};
    col_data = 4'b0000;
    accept_key(4'b0000);
    for (int k = 1; k <= 46; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (row_data[3] !== exp_seq[46 - k]) begin n_bad++; $display("FAIL bounce_row3 k=%0d: got %b, required %b", k, row_data[3], exp_seq[46 - k]); end
      n_cmp++; if (done !== (k == 46)) begin n_bad++; $display("FAIL bounce_done k=%0d: got %b, required %b", k, done, (k == 46)); end
    end
    $display("bounce: code=0000 col=0000 bounce pattern, done at clock 46");
  endtask
`endif

  initial begin
    test_reset();
    test_press_held();
    test_col_cycle();
    test_other_key();
    test_abort();
    test_reset_mid();
`ifdef KEY_EMU_BOUNCE_EN
    test_bounce();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
